// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, packs it into big-endian words, writes
// them into instruction memory and holds the CPU until the load completes. Define
// LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the CPU is released.
module imem_loader #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = MEM_BYTES / 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              pc_reset,
  output logic              done,
  output logic              error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  logic [2:0]        state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              pc_reset_q, pc_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        accept;
  logic [31:0] word;
  logic        last_word;

  // in_ready is a pure function of state so the sender never sees a combinational loop.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN, S_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:        in_ready = 1'b1;
`endif
      default:       in_ready = 1'b0;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign word      = {shift_q, in_byte};
  assign last_word = (word_cnt_q == n_q - 8'd1);

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no branch infers a latch.
    state_d     = state_q;
    n_d         = n_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    pc_reset_d  = 1'b0;
    done_d      = done_q;
    error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end

      S_LEN: begin
        if (accept) begin
          if (in_byte == 8'd0 || in_byte > MAX_N) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end else begin
            state_d    = S_DATA;
            n_d        = in_byte;
            word_cnt_d = 8'd0;
            byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = in_byte;
`endif
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d    = word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ in_byte;
`endif
          // The write is registered, so it overlaps reception of the next word's first byte.
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_W'({word_cnt_q, 2'b00});
            mem_wdata_d = word;
            word_cnt_d  = word_cnt_q + 8'd1;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state_d    = S_CSUM;
`else
              state_d    = S_DONE;
              pc_reset_d = 1'b1;
`endif
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_byte == csum_q) begin
            state_d    = S_DONE;
            pc_reset_d = 1'b1;
          end else begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
          end
        end
      end
`endif

      S_DONE: begin
        if (start) begin
          state_d    = S_LEN;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
        end else if (pc_reset_q) begin
          // The CPU is released one cycle after the PC-reset pulse.
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end
      end

      S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          error_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (reset) begin
      state_q     <= S_IDLE;
      n_q         <= 8'd0;
      word_cnt_q  <= 8'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_hold_q  <= 1'b1;
      pc_reset_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      pc_reset_q  <= pc_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign pc_reset  = pc_reset_q;
  assign done      = done_q;
  assign error     = error_q;

  a_addr_aligned: assert property (@(posedge clk) disable iff (reset) mem_addr[1:0] == 2'b00);
  a_pc_single:    assert property (@(posedge clk) disable iff (reset) pc_reset |=> !pc_reset);
  a_hold_load:    assert property (@(posedge clk) disable iff (reset) in_ready |-> cpu_hold);
  a_done_clean:   assert property (@(posedge clk) disable iff (reset) done |-> (!cpu_hold && !error));

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed table vectors, hand-written corner sequences
// and randomized sessions compared against a stream-level reference model.
module tb_imem_loader;

  logic        clk;
  logic        reset, start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, mem_we, cpu_hold, pc_reset, done, error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .pc_reset(pc_reset), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ticks = 0;

  // Monitor state, written only by the monitor process.
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int cyc = 0, pc_cnt = 0, pc_double = 0, pc_with_we = 0, pc_cyc = 0, done_cyc = 0;
  logic prev_pc = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (pc_reset) begin
      pc_cnt <= pc_cnt + 1;
      pc_cyc <= cyc;
      if (mem_we) pc_with_we <= pc_with_we + 1;
      if (prev_pc) pc_double <= pc_double + 1;
    end
    if (done && !prev_done) done_cyc <= cyc;
    prev_pc   <= pc_reset;
    prev_done <= done;
  end

  // Stream under test and expected results from the model.
  logic [7:0]  stream[$];
  logic [31:0] exp_data[$];
  logic        exp_err;
  int base_w, base_pc, base_dbl, base_pcwe;

  typedef struct {
    logic [7:0] n;
    logic       exp_err;
    int         exp_writes;
    logic [7:0] exp_last;
  } len_vec_t;
  len_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ticks++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int guard;
    in_valid = 1'b1;
    in_byte  = b;
    guard    = 0;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 20);
    in_valid = 1'b0;
    if (!acc) check("byte accepted", 32'(acc), 32'd1);
  endtask

  // Reference model: the whole session outcome from the stream format alone.
  task automatic model();
    int n;
    exp_data.delete();
    n = int'(stream[0]);
    if (n == 0 || n > 64) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++)
      exp_data.push_back({stream[4*w+1], stream[4*w+2], stream[4*w+3], stream[4*w+4]});
    exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'd0;
      for (int i = 0; i <= 4*n; i++) x ^= stream[i];
      if (stream[4*n+1] != x) exp_err = 1'b1;
    end
`endif
  endtask

  task automatic add_csum(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    foreach (stream[i]) x ^= stream[i];
    if (corrupt) x ^= 8'h5A;
    stream.push_back(x);
`else
    if (corrupt) stream.push_back(8'h00);
`endif
  endtask

  task automatic build_stream(input int n, input bit corrupt);
    stream.delete();
    stream.push_back(8'(n));
    if (n != 0 && n <= 64) begin
      for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      add_csum(corrupt);
`endif
    end
  endtask

  task automatic begin_session();
    model();
    base_w    = wr_data.size();
    base_pc   = pc_cnt;
    base_dbl  = pc_double;
    base_pcwe = pc_with_we;
    pulse_start();
  endtask

  task automatic send_all(input int gap_pct, input int start_at);
    foreach (stream[i]) begin
      if (i == start_at) start = 1'b1;
      send_byte(stream[i]);
      start = 1'b0;
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) idle($urandom_range(3, 1));
    end
  endtask

  task automatic end_session(input string name);
    int guard, n_w;
    guard = 0;
    while (!done && !error && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    check({name, " finished"}, 32'(done || error), 32'd1);
    n_w = wr_data.size() - base_w;
    check({name, " write count"}, n_w, exp_data.size());
    for (int i = 0; i < exp_data.size() && i < n_w; i++) begin
      check($sformatf("%s addr[%0d]", name, i), 32'(wr_addr[base_w+i]), 4*i);
      check($sformatf("%s data[%0d]", name, i), wr_data[base_w+i], exp_data[i]);
    end
    check({name, " error"}, 32'(error), 32'(exp_err));
    check({name, " done"}, 32'(done), 32'(!exp_err));
    check({name, " cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    check({name, " in_ready idle"}, 32'(in_ready), 32'd0);
    check({name, " pc_reset pulses"}, pc_cnt - base_pc, 32'(!exp_err));
    check({name, " pc_reset width"}, pc_double - base_dbl, 32'd0);
    if (!exp_err) begin
      check({name, " done after pc_reset"}, done_cyc - pc_cyc, 32'd1);
`ifndef LOADER_CHECKSUM_EN
      check({name, " pc_reset with last write"}, pc_with_we - base_pcwe, 32'd1);
`endif
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, " in_ready"},  32'(in_ready),  32'd0);
    check({name, " mem_we"},    32'(mem_we),    32'd0);
    check({name, " mem_addr"},  32'(mem_addr),  32'd0);
    check({name, " mem_wdata"}, mem_wdata,      32'd0);
    check({name, " cpu_hold"},  32'(cpu_hold),  32'd1);
    check({name, " pc_reset"},  32'(pc_reset),  32'd0);
    check({name, " done"},      32'(done),      32'd0);
    check({name, " error"},     32'(error),     32'd0);
  endtask

  initial begin
    logic [7:0] prog[9];
    int t0, n;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'd0;
    tick(); tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // reset and start together: reset wins, loader stays idle.
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("reset beats start", 32'(in_ready), 32'd0);

    // Two-instruction program with hand-computed words.
    prog = '{8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h02, 8'h00, 8'h04};
    stream.delete();
    foreach (prog[i]) stream.push_back(prog[i]);
    add_csum(1'b0);
    begin_session();
    send_all(0, -1);
    end_session("prog2");
    check("prog2 word0", wr_data[base_w], 32'h20080005);
    check("prog2 word1", wr_data[base_w+1], 32'h8C020004);

    // Length-byte table.
    vecs[0] = '{8'h00, 1'b1, 0,  8'h00};
    vecs[1] = '{8'h41, 1'b1, 0,  8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,  8'h00};
    vecs[3] = '{8'h01, 1'b0, 1,  8'h00};
    vecs[4] = '{8'h05, 1'b0, 5,  8'h10};
    vecs[5] = '{8'h40, 1'b0, 64, 8'hFC};
    foreach (vecs[v]) begin
      build_stream(int'(vecs[v].n), 1'b0);
      begin_session();
      send_all(20, -1);
      end_session($sformatf("len%0h", vecs[v].n));
      check($sformatf("len%0h tbl writes", vecs[v].n), wr_data.size() - base_w, vecs[v].exp_writes);
      check($sformatf("len%0h tbl error", vecs[v].n), 32'(error), 32'(vecs[v].exp_err));
      if (vecs[v].exp_writes > 0)
        check($sformatf("len%0h tbl last addr", vecs[v].n), 32'(wr_addr[wr_addr.size()-1]),
              32'(vecs[v].exp_last));
    end

    // Error, then start re-enters LEN with error cleared; the session's own start is ignored.
    build_stream(0, 1'b0);
    begin_session();
    send_all(0, -1);
    end_session("err0");
    pulse_start();
    check("err start clears error", 32'(error), 32'd0);
    check("err start ready", 32'(in_ready), 32'd1);
    check("err start hold", 32'(cpu_hold), 32'd1);

    // Idle gap of 5 cycles mid-word.
    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'h12); stream.push_back(8'h34);
    stream.push_back(8'h56); stream.push_back(8'h78);
    add_csum(1'b0);
    begin_session();
    foreach (stream[i]) begin
      send_byte(stream[i]);
      if (i == 2) idle(5);
    end
    end_session("gap");
    check("gap word", wr_data[base_w], 32'h12345678);

    // Full memory, back-to-back bytes, start pulse mid-stream.
    build_stream(64, 1'b0);
    begin_session();
    t0 = ticks;
    send_all(0, 100);
    check("full no bubbles", ticks - t0, stream.size());
    end_session("full");
    check("full last addr", 32'(wr_addr[wr_addr.size()-1]), 32'h000000FC);

`ifdef LOADER_CHECKSUM_EN
    stream.delete();
    stream.push_back(8'h01); stream.push_back(8'hAA); stream.push_back(8'hBB);
    stream.push_back(8'hCC); stream.push_back(8'hDD); stream.push_back(8'h01);
    begin_session();
    send_all(0, -1);
    end_session("csum ok");
    check("csum ok word", wr_data[base_w], 32'hAABBCCDD);
    stream[5] = 8'h00;
    begin_session();
    send_all(0, -1);
    end_session("csum bad");
    check("csum bad word", wr_data[base_w], 32'hAABBCCDD);
`endif

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(7, 0) == 0)
        n = ($urandom_range(1, 0) == 1) ? 0 : int'($urandom_range(255, 65));
      else
        n = int'($urandom_range(12, 1));
      build_stream(n, ($urandom_range(3, 0) == 0));
      begin_session();
      send_all(30, -1);
      end_session($sformatf("rand%0d", s));
    end

    // Reset after 6 data bytes of a 3-word load.
    build_stream(3, 1'b0);
    begin_session();
    for (int i = 0; i < 7; i++) send_byte(stream[i]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midreset");
    idle(5);
    check("midreset writes", wr_data.size() - base_w, 32'd1);
    check("midreset word0", wr_data[base_w], exp_data[0]);
    check("midreset still idle", 32'(in_ready), 32'd0);

    build_stream(2, 1'b0);
    begin_session();
    send_all(0, -1);
    end_session("after reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
